// File: rtl/seq_pkg.sv
// Shared definitions for the program-counter sequencer: FSM states and
// the redirect-select encodings used on BranchSel.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    // BranchSel encodings for a taken branch
    localparam logic [1:0] SEL_ABS  = 2'b00;  // jump to BranchTarget
    localparam logic [1:0] SEL_NEAR = 2'b01;  // PC + NEAR_OFS
    localparam logic [1:0] SEL_FAR  = 2'b10;  // PC + FAR_OFS
    localparam logic [1:0] SEL_INC  = 2'b11;  // PC + 1

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC computation. Produces both the redirect target
// selected by BranchSel and the plain sequential successor; all sums
// wrap modulo 2^PC_W by truncation.
module pc_next_calc
    import seq_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int NEAR_OFS = 30,
    parameter int FAR_OFS  = 60
) (
    input  logic [PC_W-1:0] pc,
    input  logic [1:0]      sel,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc_branch,
    output logic [PC_W-1:0] pc_seq
);

    localparam logic [PC_W-1:0] NEAR_INC = PC_W'(NEAR_OFS);
    localparam logic [PC_W-1:0] FAR_INC  = PC_W'(FAR_OFS);
    localparam logic [PC_W-1:0] ONE      = PC_W'(1);

    // Select the redirect target and form the sequential successor
    always_comb begin
        pc_seq    = pc + ONE;
        pc_branch = pc + ONE;
        case (sel)
            SEL_ABS:  pc_branch = target;
            SEL_NEAR: pc_branch = pc + NEAR_INC;
            SEL_FAR:  pc_branch = pc + FAR_INC;
            default:  pc_branch = pc + ONE;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE -> FETCH -> EXEC loop with branch
// redirect, stall hold and a sticky HALT. Status outputs are decoded from
// the state register so an asynchronous reset clears them immediately.
module pc_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int NEAR_OFS = 30,
    parameter int FAR_OFS  = 60
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            IMemAck,
    input  logic            Stall,
    input  logic            HaltIn,
    input  logic            BranchTaken,
    input  logic [1:0]      BranchSel,
    input  logic [PC_W-1:0] BranchTarget,
    output logic [PC_W-1:0] PC,
    output logic            IMemReq,
    output logic            Fetched,
    output logic            Busy,
    output logic            Done,
    output logic [15:0]     InstrCount
);

    state_t          state;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_branch;
    logic [PC_W-1:0] pc_seq;
    logic            fetched_q;
    logic [15:0]     count_q;

    // Retired-instruction count sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    pc_next_calc #(
        .PC_W     (PC_W),
        .NEAR_OFS (NEAR_OFS),
        .FAR_OFS  (FAR_OFS)
    ) u_next (
        .pc        (pc_q),
        .sel       (BranchSel),
        .target    (BranchTarget),
        .pc_branch (pc_branch),
        .pc_seq    (pc_seq)
    );

    // Sequencer FSM with PC, fetch pulse and instruction counter
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= ST_IDLE;
            pc_q      <= '0;
            fetched_q <= 1'b0;
            count_q   <= '0;
        end else begin
            fetched_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        state <= ST_FETCH;
                        pc_q  <= '0;
                    end
                end
                ST_FETCH: begin
                    if (IMemAck) begin
                        state     <= ST_EXEC;
                        fetched_q <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (HaltIn) begin
                        state   <= ST_HALT;
                        count_q <= sat_inc(count_q);
                    end else if (Stall) begin
                        state <= ST_EXEC;
                    end else if (BranchTaken) begin
                        state   <= ST_FETCH;
                        pc_q    <= pc_branch;
                        count_q <= sat_inc(count_q);
                    end else begin
                        state   <= ST_FETCH;
                        pc_q    <= pc_seq;
                        count_q <= sat_inc(count_q);
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign PC         = pc_q;
    assign Fetched    = fetched_q;
    assign InstrCount = count_q;
    assign IMemReq    = (state == ST_FETCH);
    assign Busy       = (state == ST_FETCH) || (state == ST_EXEC);
    assign Done       = (state == ST_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: expected PC/count pairs are queued when an EXEC
// decision is driven and compared when the next EXEC entry is seen.
module tb_pc_sequencer;

    localparam int PC_W = 8;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            Start;
    logic            IMemAck;
    logic            Stall;
    logic            HaltIn;
    logic            BranchTaken;
    logic [1:0]      BranchSel;
    logic [PC_W-1:0] BranchTarget;
    logic [PC_W-1:0] PC;
    logic            IMemReq;
    logic            Fetched;
    logic            Busy;
    logic            Done;
    logic [15:0]     InstrCount;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic [15:0]     cnt;
    } exp_t;

    exp_t sb[$];

    pc_sequencer #(.PC_W(PC_W), .NEAR_OFS(30), .FAR_OFS(60)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .IMemAck      (IMemAck),
        .Stall        (Stall),
        .HaltIn       (HaltIn),
        .BranchTaken  (BranchTaken),
        .BranchSel    (BranchSel),
        .BranchTarget (BranchTarget),
        .PC           (PC),
        .IMemReq      (IMemReq),
        .Fetched      (Fetched),
        .Busy         (Busy),
        .Done         (Done),
        .InstrCount   (InstrCount)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        Start        = 1'b0;
        Stall        = 1'b0;
        HaltIn       = 1'b0;
        BranchTaken  = 1'b0;
        BranchSel    = 2'b00;
        BranchTarget = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        Reset = 1'b0;
        sb.delete();
        tick();
        tick();
        Reset = 1'b1;
        tick();
    endtask

    // Waits for the first EXEC cycle (Fetched high); reports cycles waited
    task automatic wait_exec(output bit ok, output int waited);
        ok = 1'b0;
        waited = 0;
        for (int i = 0; i < 20; i++) begin
            if (Fetched === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
            waited++;
        end
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        clear_inputs();
        IMemAck = 1'b0;
        Reset = 1'b1;
        #2;
        Reset = 1'b0;
        #2;
        checks++;
        if (PC !== 8'd0 || IMemReq !== 1'b0 || Fetched !== 1'b0) begin
            fails++;
            $display("FAIL reset_pc_req: PC=%0d IMemReq=%b Fetched=%b want 0/0/0", PC, IMemReq, Fetched);
        end
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || InstrCount !== 16'd0) begin
            fails++;
            $display("FAIL reset_status: Busy=%b Done=%b Cnt=%0d want 0/0/0", Busy, Done, InstrCount);
        end
        tick();
        Reset = 1'b1;
        tick();
        tick();
        checks++;
        if (Busy !== 1'b0 || IMemReq !== 1'b0) begin
            fails++;
            $display("FAIL idle_without_start: Busy=%b IMemReq=%b want 0/0", Busy, IMemReq);
        end
        e.pc = 8'd0;
        e.cnt = 16'd0;
    endtask

    task automatic test_sequential();
        exp_t e;
        bit ok;
        int waited;
        logic [PC_W-1:0] mpc;
        logic [15:0] mcnt;
        do_reset();
        IMemAck = 1'b1;
        mpc = 8'd0;
        mcnt = 16'd0;
        e.pc = mpc;
        e.cnt = mcnt;
        sb.push_back(e);
        pulse_start();
        checks++;
        if (IMemReq !== 1'b1 || Busy !== 1'b1) begin
            fails++;
            $display("FAIL start_latency: IMemReq=%b Busy=%b want 1/1", IMemReq, Busy);
        end
        for (int k = 0; k < 6; k++) begin
            wait_exec(ok, waited);
            checks++;
            if (!ok || waited != 1) begin
                fails++;
                $display("FAIL seq_fetch_timing: ok=%0d waited=%0d want 1/1", ok, waited);
            end
            e = sb.pop_front();
            checks++;
            if (PC !== e.pc || InstrCount !== e.cnt) begin
                fails++;
                $display("FAIL seq_step%0d: PC=%0d Cnt=%0d want %0d/%0d", k, PC, InstrCount, e.pc, e.cnt);
            end
            if (k < 5) begin
                mpc = mpc + 8'd1;
                mcnt = mcnt + 16'd1;
                e.pc = mpc;
                e.cnt = mcnt;
                sb.push_back(e);
                tick();
            end
        end
    endtask

    // Continues from PC=5 left in EXEC by test_sequential
    task automatic test_abs_branch();
        exp_t e;
        bit ok;
        int waited;
        BranchTaken = 1'b1;
        BranchSel = 2'b00;
        BranchTarget = 8'hA0;
        e.pc = 8'hA0;
        e.cnt = 16'd6;
        sb.push_back(e);
        tick();
        clear_inputs();
        wait_exec(ok, waited);
        e = sb.pop_front();
        checks++;
        if (!ok || PC !== e.pc || InstrCount !== e.cnt) begin
            fails++;
            $display("FAIL abs_branch: ok=%0d PC=%h Cnt=%0d want %h/%0d", ok, PC, InstrCount, e.pc, e.cnt);
        end
    endtask

    task automatic test_wrap_branch();
        exp_t e;
        bit ok;
        int waited;
        logic [1:0] sels [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [PC_W-1:0] pcs [4] = '{8'd250, 8'd24, 8'd84, 8'd85};
        do_reset();
        IMemAck = 1'b1;
        e.pc = 8'd0;
        e.cnt = 16'd0;
        sb.push_back(e);
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            wait_exec(ok, waited);
            e = sb.pop_front();
            checks++;
            if (!ok || PC !== e.pc || InstrCount !== e.cnt) begin
                fails++;
                $display("FAIL branch_step%0d: ok=%0d PC=%0d Cnt=%0d want %0d/%0d", k, ok, PC, InstrCount, e.pc, e.cnt);
            end
            if (k < 4) begin
                BranchTaken = 1'b1;
                BranchSel = sels[k];
                BranchTarget = 8'd250;
                e.pc = pcs[k];
                e.cnt = 16'(k + 1);
                sb.push_back(e);
                tick();
                // Garbage redirect held through FETCH must not move PC
                BranchTaken = 1'b1;
                BranchSel = 2'b00;
                BranchTarget = 8'h33;
            end
        end
        clear_inputs();
    endtask

    task automatic test_stall();
        exp_t e;
        bit ok;
        int waited;
        int pulses;
        do_reset();
        IMemAck = 1'b0;
        e.pc = 8'd0;
        e.cnt = 16'd0;
        sb.push_back(e);
        pulse_start();
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if (IMemReq !== 1'b1 || PC !== 8'd0 || Fetched !== 1'b0) begin
            fails++;
            $display("FAIL fetch_hold: IMemReq=%b PC=%0d Fetched=%b want 1/0/0", IMemReq, PC, Fetched);
        end
        IMemAck = 1'b1;
        tick();
        IMemAck = 1'b0;
        pulses = 0;
        wait_exec(ok, waited);
        e = sb.pop_front();
        checks++;
        if (!ok || PC !== e.pc) begin
            fails++;
            $display("FAIL stall_entry: ok=%0d PC=%0d want %0d", ok, PC, e.pc);
        end
        if (Fetched === 1'b1) pulses++;
        Stall = 1'b1;
        BranchTaken = 1'b1;
        BranchSel = 2'b10;
        Start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (Fetched === 1'b1) pulses++;
            checks++;
            if (PC !== 8'd0 || InstrCount !== 16'd0 || Busy !== 1'b1 || IMemReq !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold%0d: PC=%0d Cnt=%0d Busy=%b IMemReq=%b want 0/0/1/0", k, PC, InstrCount, Busy, IMemReq);
            end
        end
        checks++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL fetched_pulses: got %0d want 1", pulses);
        end
        Stall = 1'b0;
        Start = 1'b0;
        e.pc = 8'd60;
        e.cnt = 16'd1;
        sb.push_back(e);
        IMemAck = 1'b1;
        tick();
        clear_inputs();
        wait_exec(ok, waited);
        e = sb.pop_front();
        checks++;
        if (!ok || PC !== e.pc || InstrCount !== e.cnt) begin
            fails++;
            $display("FAIL stall_then_branch: ok=%0d PC=%0d Cnt=%0d want %0d/%0d", ok, PC, InstrCount, e.pc, e.cnt);
        end
    endtask

    task automatic test_halt();
        exp_t e;
        bit ok;
        int waited;
        do_reset();
        IMemAck = 1'b1;
        pulse_start();
        for (int k = 0; k < 7; k++) begin
            wait_exec(ok, waited);
            tick();
        end
        wait_exec(ok, waited);
        checks++;
        if (!ok || PC !== 8'd7 || InstrCount !== 16'd7) begin
            fails++;
            $display("FAIL halt_setup: ok=%0d PC=%0d Cnt=%0d want 7/7", ok, PC, InstrCount);
        end
        HaltIn = 1'b1;
        BranchTaken = 1'b1;
        BranchSel = 2'b00;
        BranchTarget = 8'h55;
        tick();
        clear_inputs();
        checks++;
        if (Done !== 1'b1 || PC !== 8'd7 || InstrCount !== 16'd8 || Busy !== 1'b0 || IMemReq !== 1'b0) begin
            fails++;
            $display("FAIL halt_entry: Done=%b PC=%0d Cnt=%0d Busy=%b Req=%b want 1/7/8/0/0", Done, PC, InstrCount, Busy, IMemReq);
        end
        Start = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        Start = 1'b0;
        checks++;
        if (Done !== 1'b1 || PC !== 8'd7 || InstrCount !== 16'd8 || IMemReq !== 1'b0) begin
            fails++;
            $display("FAIL halt_sticky: Done=%b PC=%0d Cnt=%0d Req=%b want 1/7/8/0", Done, PC, InstrCount, IMemReq);
        end
    endtask

    task automatic test_reset_mid_fetch();
        bit ok;
        int waited;
        do_reset();
        IMemAck = 1'b1;
        pulse_start();
        wait_exec(ok, waited);
        tick();
        IMemAck = 1'b0;
        tick();
        checks++;
        if (IMemReq !== 1'b1 || PC !== 8'd1 || InstrCount !== 16'd1) begin
            fails++;
            $display("FAIL mid_fetch_setup: Req=%b PC=%0d Cnt=%0d want 1/1/1", IMemReq, PC, InstrCount);
        end
        #2;
        Reset = 1'b0;
        #1;
        checks++;
        if (IMemReq !== 1'b0 || PC !== 8'd0 || InstrCount !== 16'd0 || Busy !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: Req=%b PC=%0d Cnt=%0d Busy=%b want 0/0/0/0", IMemReq, PC, InstrCount, Busy);
        end
        tick();
        Reset = 1'b1;
        IMemAck = 1'b1;
        tick();
        tick();
        checks++;
        if (Busy !== 1'b0 || PC !== 8'd0) begin
            fails++;
            $display("FAIL resume_needs_start: Busy=%b PC=%0d want 0/0", Busy, PC);
        end
        pulse_start();
        checks++;
        if (IMemReq !== 1'b1 || PC !== 8'd0) begin
            fails++;
            $display("FAIL restart: Req=%b PC=%0d want 1/0", IMemReq, PC);
        end
    endtask

    initial begin
        IMemAck = 1'b0;
        test_reset();
        test_sequential();
        test_abs_branch();
        test_wrap_branch();
        test_stall();
        test_halt();
        test_reset_mid_fetch();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
